// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access sizes, bus widths
// and the AXI response code that counts as success.
package ysyx_25020037_lsu_pkg;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_PASS_W = 70;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_OUT
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Byte-lane steering: store data/strobes toward the bus and load data
// extraction/extension from the bus. Purely combinational.
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);
  logic [31:0] repl;
  logic [63:0] rot;
  logic [4:0]  sh;
  logic [31:0] rshift;

  always_comb begin
    sh = {addr_lo, 3'b000};
    case (mem_size)
      SZ_B: begin
        repl  = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        repl  = {2{store_data[15:0]}};
        wstrb = 4'b0011 << addr_lo;
      end
      default: begin
        repl  = store_data;
        wstrb = 4'b1111 << addr_lo;
      end
    endcase
    // Rotate rather than shift so replicated lanes stay intact on every byte.
    rot   = {repl, repl} << sh;
    wdata = rot[63:32];

    rshift = rdata >> sh;
    case (mem_size)
      SZ_B:    load_data = load_unsigned ? {24'd0, rshift[7:0]}
                                         : {{24{rshift[7]}}, rshift[7:0]};
      SZ_H:    load_data = load_unsigned ? {16'd0, rshift[15:0]}
                                         : {{16{rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end
endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: one execute result per handshake, at most one AXI4-Lite access.
// Define LSU_ACCESS_FAULT_EN to report non-OKAY bus responses on lsu_fault.
module ysyx_25020037_lsu
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int PASS_W = LSU_PASS_W,
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              lsu_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [PASS_W-1:0] pass_in,
  output logic              lsu_valid,
  input  logic              wbu_ready,
  output logic [31:0]       lsu_result,
  output logic [PASS_W-1:0] pass_out,
  output logic              lsu_fault,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  lsu_state_e  state;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        uns_q;
  logic [1:0]  al_size;
  logic [1:0]  al_addr;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_load;
  logic        rd_err;
  logic        wr_err;

  assign lsu_ready = (state == S_IDLE);
  // Store lanes come from the live inputs at acceptance; load extraction uses latched fields.
  assign al_size = lsu_ready ? mem_size : size_q;
  assign al_addr = lsu_ready ? alu_result[1:0] : addr_lo_q;

`ifdef LSU_ACCESS_FAULT_EN
  assign rd_err = (rresp != RESP_OKAY);
  assign wr_err = (bresp != RESP_OKAY);
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  ysyx_25020037_lsu_align u_align (
    .mem_size     (al_size),
    .addr_lo      (al_addr),
    .load_unsigned(uns_q),
    .store_data   (store_data),
    .rdata        (rdata),
    .wdata        (al_wdata),
    .wstrb        (al_wstrb),
    .load_data    (al_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      size_q     <= SZ_B;
      addr_lo_q  <= 2'd0;
      uns_q      <= 1'b0;
      lsu_valid  <= 1'b0;
      lsu_result <= '0;
      pass_out   <= '0;
      lsu_fault  <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (exu_valid) begin
            size_q     <= mem_size;
            addr_lo_q  <= alu_result[1:0];
            uns_q      <= load_unsigned;
            pass_out   <= pass_in;
            lsu_result <= alu_result;
            if (is_load) begin
              araddr  <= alu_result[ADDR_W-1:0];
              arvalid <= 1'b1;
              state   <= S_RD_ADDR;
            end else if (is_store) begin
              awaddr  <= alu_result[ADDR_W-1:0];
              wdata   <= al_wdata;
              wstrb   <= al_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR_REQ;
            end else begin
              lsu_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            lsu_valid <= 1'b1;
            state     <= S_OUT;
            if (rd_err) begin
              lsu_fault  <= 1'b1;
              lsu_result <= 32'(araddr);
            end else begin
              lsu_result <= al_load;
            end
          end
        end
        S_WR_REQ: begin
          // Address and data channels retire independently, possibly in the same cycle.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            lsu_valid <= 1'b1;
            state     <= S_OUT;
            if (wr_err) begin
              lsu_fault  <= 1'b1;
              lsu_result <= 32'(awaddr);
            end
          end
        end
        S_OUT: begin
          if (wbu_ready) begin
            lsu_valid <= 1'b0;
            lsu_fault <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Scoreboard bench for ysyx_25020037_lsu with a delay-configurable AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_ysyx_25020037_lsu;
  localparam int PW = 70;

  logic          clk = 1'b0;
  logic          rst;
  logic          exu_valid, lsu_ready, is_load, is_store, load_unsigned;
  logic [1:0]    mem_size;
  logic [31:0]   alu_result, store_data;
  logic [PW-1:0] pass_in, pass_out;
  logic          lsu_valid, wbu_ready, lsu_fault;
  logic [31:0]   lsu_result;
  logic [31:0]   araddr, rdata, awaddr, wdata;
  logic          arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic          bvalid, bready;
  logic [1:0]    rresp, bresp;
  logic [3:0]    wstrb;

  ysyx_25020037_lsu dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
    .is_load(is_load), .is_store(is_store), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .alu_result(alu_result), .store_data(store_data),
    .pass_in(pass_in), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .lsu_result(lsu_result), .pass_out(pass_out), .lsu_fault(lsu_fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_hs = 0;
  logic aw_seen = 1'b0, w_seen = 1'b0;
  logic [31:0] rd_data_v;
  logic [1:0]  rd_resp_v, wr_resp_v;

  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign rdata   = rd_data_v;
  assign rresp   = rd_resp_v;
  assign bresp   = wr_resp_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      rvalid <= 1'b0; bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_cnt <= 0;
        if (r_delay == 0) rvalid <= 1'b1;
        else r_cnt <= r_delay;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (r_cnt == 1) begin rvalid <= 1'b1; r_cnt <= 0; end
      else if (r_cnt > 1) r_cnt <= r_cnt - 1;
      if (rvalid && rready) rvalid <= 1'b0;

      if (awvalid && awready) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) w_cnt <= 0; else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready) w_seen <= 1'b1;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0]   result;
    logic [PW-1:0] pass;
    logic          fault;
    int            lat;
    int            issue_cyc;
  } exp_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } wexp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  wexp_t       exp_w[$];

  int   cyc = 0;
  int   out_count = 0;
  int   valid_start = 0;
  int   axi_act = 0;
  logic prev_valid = 1'b0;
  exp_t  mon_e;
  wexp_t mon_w;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (lsu_valid && !prev_valid) valid_start = cyc;
      prev_valid = lsu_valid;
      if (arvalid || awvalid || wvalid || rready || bready) axi_act++;
      if (!lsu_valid) check("fault_clear", lsu_fault, 1'b0);
      if (lsu_valid && wbu_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: actual=%0h required=none", lsu_result);
        end else begin
          mon_e = exp_q.pop_front();
          check("lsu_result", lsu_result, mon_e.result);
          check("pass_out", pass_out, mon_e.pass);
          check("lsu_fault", lsu_fault, mon_e.fault);
          if (mon_e.lat >= 0) check("latency", valid_start - mon_e.issue_cyc, mon_e.lat);
        end
        out_count++;
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", araddr, 32'hx);
        else check("araddr", araddr, exp_ar.pop_front());
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", awaddr, 32'hx);
        else check("awaddr", awaddr, exp_aw.pop_front());
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) check("w_unexpected", wdata, 32'hx);
        else begin
          mon_w = exp_w.pop_front();
          check("wdata", wdata, mon_w.data);
          check("wstrb", wstrb, mon_w.strb);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [PW-1:0] pass,
                       input logic [31:0] exp_res, input logic exp_flt, input int lat,
                       input logic want);
    int n = 0;
    while (!lsu_ready && n < 100) begin @(negedge clk); n++; end
    if (!lsu_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: actual=%0h required=1", lsu_ready);
      return;
    end
    is_load = ld; is_store = st; mem_size = sz; load_unsigned = uns;
    alu_result = alu; store_data = sd; pass_in = pass; exu_valid = 1'b1;
    if (want) exp_q.push_back('{exp_res, pass, exp_flt, lat, cyc});
    @(negedge clk);
    exu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (out_count < target && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (out_count < target) begin
      errors++;
      $display("FAIL out_timeout: actual=%0d required=%0d", out_count, target);
    end
  endtask

  int   outs = 0;
  int   act0, b0, n;
  logic [31:0] fexp_res;
  logic        fexp_flt;

  initial begin
    rst = 1'b1; exu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_size = 2'd0;
    load_unsigned = 1'b0; alu_result = '0; store_data = '0; pass_in = '0; wbu_ready = 1'b1;
    rd_data_v = '0; rd_resp_v = 2'b00; wr_resp_v = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_lsu_valid", lsu_valid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_result", lsu_result, 32'h0);
    check("rst_pass", pass_out, {PW{1'b0}});
    check("rst_fault", lsu_fault, 1'b0);
    check("rst_ready", lsu_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Non-memory pass-through, 1-cycle latency, no bus traffic
    act0 = axi_act;
    issue(0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 70'h3F_0123_4567_89AB_CDEF, 32'h0000_1234, 0, 1, 1);
    outs++; wait_out(outs);
    check("nonmem_no_axi", axi_act - act0, 0);

    // Loads with a zero-wait slave
    rd_data_v = 32'h8012_3456; exp_ar.push_back(32'h8000_0003);
    issue(1, 0, 2'd0, 0, 32'h8000_0003, 32'h0, 70'h1, 32'hFFFF_FF80, 0, 3, 1);
    outs++; wait_out(outs);
    exp_ar.push_back(32'h8000_0003);
    issue(1, 0, 2'd0, 1, 32'h8000_0003, 32'h0, 70'h2, 32'h0000_0080, 0, 3, 1);
    outs++; wait_out(outs);
    rd_data_v = 32'hBEEF_0000; exp_ar.push_back(32'h8000_0002);
    issue(1, 0, 2'd1, 0, 32'h8000_0002, 32'h0, 70'h3, 32'hFFFF_BEEF, 0, 3, 1);
    outs++; wait_out(outs);
    rd_data_v = 32'h1234_8001; exp_ar.push_back(32'h8000_0000);
    issue(1, 0, 2'd1, 1, 32'h8000_0000, 32'h0, 70'h4, 32'h0000_8001, 0, 3, 1);
    outs++; wait_out(outs);
    rd_data_v = 32'h0000_007F; exp_ar.push_back(32'h8000_0008);
    issue(1, 0, 2'd3, 0, 32'h8000_0008, 32'h0, 70'h5, 32'h0000_007F, 0, 3, 1);
    outs++; wait_out(outs);

    // Load with arready wait 2 and rvalid wait 3
    ar_delay = 2; r_delay = 3;
    rd_data_v = 32'hCAFE_F00D; exp_ar.push_back(32'h8000_0004);
    issue(1, 0, 2'd2, 0, 32'h8000_0004, 32'h0, 70'h6, 32'hCAFE_F00D, 0, 8, 1);
    outs++; wait_out(outs);
    ar_delay = 0; r_delay = 0;

    // Stores
    exp_aw.push_back(32'h8000_0001); exp_w.push_back('{32'hABAB_ABAB, 4'b0010});
    issue(0, 1, 2'd0, 0, 32'h8000_0001, 32'h0000_00AB, 70'h7, 32'h8000_0001, 0, 3, 1);
    outs++; wait_out(outs);
    exp_aw.push_back(32'h8000_0002); exp_w.push_back('{32'hBEEF_BEEF, 4'b1100});
    issue(0, 1, 2'd1, 0, 32'h8000_0002, 32'h1234_BEEF, 70'h8, 32'h8000_0002, 0, 3, 1);
    outs++; wait_out(outs);
    w_delay = 3; b0 = b_hs;
    exp_aw.push_back(32'h8000_0000); exp_w.push_back('{32'h1122_3344, 4'b1111});
    issue(0, 1, 2'd2, 0, 32'h8000_0000, 32'h1122_3344, 70'h9, 32'h8000_0000, 0, 6, 1);
    outs++; wait_out(outs);
    check("sw_one_bresp", b_hs - b0, 1);
    w_delay = 0;

    // Backpressure from writeback for 5 cycles
    wbu_ready = 1'b0;
    rd_data_v = 32'h55AA_55AA; exp_ar.push_back(32'h8000_0010);
    issue(1, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 70'h2A_AAAA_0000_5555_1111, 32'h55AA_55AA, 0, 3, 1);
    n = 0;
    while (!lsu_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", lsu_valid, 1'b1);
      check("bp_result", lsu_result, 32'h55AA_55AA);
      check("bp_pass", pass_out, 70'h2A_AAAA_0000_5555_1111);
      check("bp_ready", lsu_ready, 1'b0);
      @(negedge clk);
    end
    wbu_ready = 1'b1;
    outs++; wait_out(outs);

    // Reset while the read address waits for arready
    ar_delay = 1000;
    issue(1, 0, 2'd2, 0, 32'h8000_0020, 32'h0, 70'hA, 32'h0, 0, -1, 0);
    @(negedge clk);
    check("pre_rst_arvalid", arvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_awvalid", awvalid, 1'b0);
    check("mid_rst_wvalid", wvalid, 1'b0);
    check("mid_rst_bready", bready, 1'b0);
    check("mid_rst_lsu_valid", lsu_valid, 1'b0);
    check("mid_rst_ready", lsu_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0; ar_delay = 0; prev_valid = 1'b0;
    @(negedge clk);
    rd_data_v = 32'h0BAD_F00D; exp_ar.push_back(32'h8000_0024);
    issue(1, 0, 2'd2, 0, 32'h8000_0024, 32'h0, 70'hB, 32'h0BAD_F00D, 0, 3, 1);
    outs++; wait_out(outs);

    // Slave error response on a load at address 0
`ifdef LSU_ACCESS_FAULT_EN
    fexp_res = 32'h0000_0000; fexp_flt = 1'b1;
`else
    fexp_res = 32'hDEAD_BEEF; fexp_flt = 1'b0;
`endif
    rd_data_v = 32'hDEAD_BEEF; rd_resp_v = 2'b10; exp_ar.push_back(32'h0);
    issue(1, 0, 2'd2, 0, 32'h0000_0000, 32'h0, 70'hC, fexp_res, fexp_flt, 3, 1);
    outs++; wait_out(outs);
    rd_resp_v = 2'b00;
    repeat (2) @(negedge clk);

    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_ar_q_empty", exp_ar.size(), 0);
    check("end_aw_q_empty", exp_aw.size(), 0);
    check("end_w_q_empty", exp_w.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
